keccak_byte_packer: RTL and testbench
=====================================

KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 64: keccak input word width in bits; only 64 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_data  input  8  message byte.
REQ-005 SHALL have port s_valid  input  1  s_data is valid.
REQ-006 SHALL have port s_last  input  1  s_data is the final byte of the message; sampled only with s_valid.
REQ-007 SHALL have port s_ready  output  1  byte accepted on an edge where s_valid=1 and s_ready=1.
REQ-008 SHALL have port core_clr  output  1  one-cycle clear pulse to the keccak core's reset.
REQ-009 SHALL have port word  output  64  packed word to the keccak core's in.
REQ-010 SHALL have port word_valid  output  1  drives the keccak core's in_ready.
REQ-011 SHALL have port word_last  output  1  drives the keccak core's is_last.
REQ-012 SHALL have port word_bytes  output  3  drives the keccak core's byte_num; meaningful only when word_last=1.
REQ-013 SHALL have port buffer_full  input  1  from the keccak core; word consumed on an edge where word_valid=1 and buffer_full=0.
REQ-014 SHALL have port hash_done  input  1  the keccak core's out_ready.

Function
REQ-015 SHALL implement states IDLE, CLR, FILL, EMPTY, WAIT.
REQ-016 IDLE: s_ready=0; go to CLR when s_valid=1.
REQ-017 CLR: core_clr=1 for exactly one cycle, s_ready=0, then go to FILL.
REQ-018 FILL: s_ready = !word_valid || !buffer_full, so the output register is free or is being consumed on that edge.
REQ-019 SHALL place the k-th accepted byte of a word (k=0..7) in pack[63-8k -: 8], with unused low bytes zero.
REQ-020 An accepted non-last byte at count 7 SHALL load word from pack, set word_valid=1 and word_last=0, and clear the count.
REQ-021 An accepted last byte at count n-1 with n<8 SHALL load word, set word_last=1 and word_bytes=n, and go to WAIT.
REQ-022 An accepted last byte at count 7 SHALL load the full word with word_last=0 and go to EMPTY.
REQ-023 EMPTY: after the full word is consumed, present word=0, word_last=1, word_bytes=0, then go to WAIT.
REQ-024 word, word_last and word_bytes SHALL hold stable while word_valid=1 and buffer_full=1.
REQ-025 word_valid SHALL clear on consumption unless a new word loads on the same edge.
REQ-026 WAIT: s_ready=0; go to IDLE on the first edge with word_valid=0 and hash_done=1.
REQ-027 SHALL keep at most one output word outstanding.
REQ-028 s_ready SHALL have no combinational path from s_valid.

Reset
REQ-029 Reset SHALL force state=IDLE, count=0, pack=0, and word, word_valid, word_last, word_bytes, core_clr and s_ready all to 0.
REQ-030 Reset asserted mid-message SHALL discard the partial word and any pending word without emitting either.

Structure
REQ-031 Package keccak_pkg SHALL hold the state enum, WORD_W=64 and BYTE_NUM_W=3.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Send "The quick brown fox jumps over the lazy dog" (43 B) with buffer_full=0 -> core_clr pulse, then words "The quic", "k brown ", "fox jump", "s over t", "he lazy ", then 64'h646F670000000000 with word_last=1, word_bytes=3.
REQ-034 Send A1 A2 A3 A4 A5 -> single word 64'hA1A2A3A4A5000000, word_last=1, word_bytes=5.
REQ-035 Send 8 B c2 06 34 f3 57 f4 21 fb -> word 64'hc20634f357f421fb with word_last=0, then 64'h0 with word_last=1, word_bytes=0.
REQ-036 Hold buffer_full=1 for 3 cycles while a word is pending -> word stays stable, s_ready=0, no byte lost; the word is consumed on the first edge with buffer_full=0.
REQ-037 Assert reset after 5 bytes of a 12-byte message -> all outputs 0 next cycle; a following 5-byte message yields exactly one word preceded by a fresh core_clr.
REQ-038 In WAIT, offer a byte before hash_done -> s_ready stays 0; after hash_done=1 -> IDLE, then CLR.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types and widths for the keccak byte packer: the control-state encoding
// and the core-facing word and byte-count widths.
package keccak_pkg;

  localparam int WORD_W     = 64;
  localparam int BYTE_NUM_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FILL,
    EMPTY,
    WAIT
  } state_t;

endpackage

// File: rtl/keccak_byte_packer_if.sv
// Byte-stream input and keccak-core word output of the packer, grouped as one bundle.
// The slave modport is the packer's view; the master modport is the environment's view.
interface keccak_byte_packer_if;
  import keccak_pkg::*;

  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;

  logic                  core_clr;
  logic [WORD_W-1:0]     word;
  logic                  word_valid;
  logic                  word_last;
  logic [BYTE_NUM_W-1:0] word_bytes;
  logic                  buffer_full;
  logic                  hash_done;

  modport slave (
    input  s_data, s_valid, s_last, buffer_full, hash_done,
    output s_ready, core_clr, word, word_valid, word_last, word_bytes
  );

  modport master (
    output s_data, s_valid, s_last, buffer_full, hash_done,
    input  s_ready, core_clr, word, word_valid, word_last, word_bytes
  );

endinterface

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream MSB-first into 64-bit words for a keccak core, clearing the
// core before each message and appending a zero-length final word when needed.
module keccak_byte_packer #(
  parameter int WORD_W = 64
) (
  input logic                  clk,
  input logic                  reset,
  keccak_byte_packer_if.slave  bus
);
  import keccak_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        count;
  logic [WORD_W-1:0] pack;
  logic [WORD_W-1:0] pack_ins;
  logic              out_free;
  logic              consume;
  logic              accept;
  logic              load_empty;

  // The output register can take a new word if it is empty or drains on this edge.
  assign out_free = !bus.word_valid || !bus.buffer_full;
  assign consume  = bus.word_valid && !bus.buffer_full;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pack_ins = pack;
    pack_ins[WORD_W - 1 - 8 * int'(count) -: 8] = bus.s_data;
  end

  always_comb begin
    state_nxt    = state;
    bus.s_ready  = 1'b0;
    bus.core_clr = 1'b0;
    accept       = 1'b0;
    load_empty   = 1'b0;
    unique case (state)
      IDLE: if (bus.s_valid) state_nxt = CLR;
      CLR: begin
        bus.core_clr = 1'b1;
        state_nxt    = FILL;
      end
      FILL: begin
        bus.s_ready = out_free;
        accept      = out_free && bus.s_valid;
        if (accept && bus.s_last) state_nxt = (count == 3'd7) ? EMPTY : WAIT;
      end
      EMPTY: begin
        if (out_free) begin
          load_empty = 1'b1;
          state_nxt  = WAIT;
        end
      end
      WAIT: if (!bus.word_valid && bus.hash_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= '0;
      pack           <= '0;
      bus.word       <= '0;
      bus.word_valid <= 1'b0;
      bus.word_last  <= 1'b0;
      bus.word_bytes <= '0;
    end else begin
      if (consume) bus.word_valid <= 1'b0;
      if (accept) begin
        if (count == 3'd7 || bus.s_last) begin
          // A last byte that fills the word is sent as a full word; the zero-length
          // terminator follows from EMPTY.
          bus.word       <= pack_ins;
          bus.word_valid <= 1'b1;
          bus.word_last  <= bus.s_last && (count != 3'd7);
          bus.word_bytes <= (bus.s_last && (count != 3'd7)) ? count + 3'd1 : 3'd0;
          pack           <= '0;
          count          <= '0;
        end else begin
          pack  <= pack_ins;
          count <= count + 3'd1;
        end
      end else if (load_empty) begin
        bus.word       <= '0;
        bus.word_valid <= 1'b1;
        bus.word_last  <= 1'b1;
        bus.word_bytes <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Scoreboard bench for keccak_byte_packer: directed and random messages, core
// back-pressure, WAIT-state probing and mid-message reset.
module tb_keccak_byte_packer;
  import keccak_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    bit          is_clr;
    logic [63:0] w;
    bit          last;
    logic [2:0]  nb;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   bf_mode = 0;  // 0: never full, 1: random, 2: held full
  exp_t expq[$];

  keccak_byte_packer_if bus();
  keccak_byte_packer #(.WORD_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t clr_ev();
    exp_t e;
    e = '{is_clr: 1'b1, w: 64'h0, last: 1'b0, nb: 3'd0};
    return e;
  endfunction

  function automatic exp_t word_ev(input logic [63:0] w, input bit last, input logic [2:0] nb);
    exp_t e;
    e = '{is_clr: 1'b0, w: w, last: last, nb: nb};
    return e;
  endfunction

  // Reference model: a message becomes 8-byte chunks, first byte most significant,
  // a short final chunk is marked last with its length; an exact multiple of 8
  // is closed by an empty last word.
  function automatic void push_model(input byte_q_t msg);
    int n;
    n = msg.size();
    expq.push_back(clr_ev());
    for (int base = 0; base < n; base += 8) begin
      int          len;
      logic [63:0] w;
      len = (n - base < 8) ? n - base : 8;
      w   = 64'h0;
      for (int j = 0; j < len; j++) w = w | (64'(msg[base + j]) << (56 - 8 * j));
      expq.push_back(word_ev(w, len < 8, (len < 8) ? 3'(len) : 3'd0));
    end
    if (n % 8 == 0) expq.push_back(word_ev(64'h0, 1'b1, 3'd0));
  endfunction

  initial begin
    bus.buffer_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bf_mode)
        1:       bus.buffer_full = ($urandom_range(0, 2) == 0);
        2:       bus.buffer_full = 1'b1;
        default: bus.buffer_full = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every core clear and every consumed word.
  logic        prev_clr = 1'b0;
  bit          held = 1'b0;
  logic [63:0] held_w;
  logic        held_l;
  logic [2:0]  held_b;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_clr = 1'b0;
      held     = 1'b0;
    end else begin
      if (bus.core_clr) begin
        check("clr_single_cycle", 64'(prev_clr), 64'(0));
        check("clr_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          mon_e = expq.pop_front();
          check("clr_order", 64'(mon_e.is_clr), 64'(1));
        end
      end
      prev_clr = bus.core_clr;
      if (held) begin
        check("hold_valid", 64'(bus.word_valid), 64'(1));
        check("hold_word", bus.word, held_w);
        check("hold_last", 64'(bus.word_last), 64'(held_l));
        check("hold_bytes", 64'(bus.word_bytes), 64'(held_b));
      end
      if (bus.word_valid && bus.buffer_full) begin
        check("stall_s_ready", 64'(bus.s_ready), 64'(0));
        held   = 1'b1;
        held_w = bus.word;
        held_l = bus.word_last;
        held_b = bus.word_bytes;
      end else begin
        held = 1'b0;
      end
      if (bus.word_valid && !bus.buffer_full) begin
        check("word_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          mon_e = expq.pop_front();
          check("word_kind", 64'(mon_e.is_clr), 64'(0));
          check("word_data", bus.word, mon_e.w);
          check("word_last", 64'(bus.word_last), 64'(mon_e.last));
          if (mon_e.last) check("word_bytes", 64'(bus.word_bytes), 64'(mon_e.nb));
        end
      end
    end
  end

  task automatic send_msg(input byte_q_t msg, input int unsigned gap_max, input bit mark_last);
    int n;
    for (int i = 0; i < msg.size(); i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = msg[i];
      bus.s_last  = mark_last && (i == msg.size() - 1);
      n = 0;
      @(negedge clk);
      while (!bus.s_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) begin
        $display("FAIL s_ready_timeout: byte %0d never accepted", i);
        $fatal(1, "byte acceptance timeout");
      end
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic finish_msg(input bit probe);
    int n;
    n = 0;
    @(negedge clk);
    while ((expq.size() != 0 || bus.word_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      $display("FAIL drain_timeout: %0d events still pending", expq.size());
      $fatal(1, "drain timeout");
    end
    tick();
    if (probe) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hEE;
      repeat (4) begin
        @(negedge clk);
        check("wait_s_ready", 64'(bus.s_ready), 64'(0));
      end
      tick();
      bus.s_valid = 1'b0;
    end
    bus.hash_done = 1'b1;
    tick();
    bus.hash_done = 1'b0;
  endtask

  task automatic stall_probe();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.word_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      $display("FAIL stall_timeout: no word presented");
      $fatal(1, "stall timeout");
    end
    repeat (3) begin
      check("stall_pending", 64'(bus.word_valid), 64'(1));
      check("stall_no_accept", 64'(bus.s_ready), 64'(0));
      @(negedge clk);
    end
    bf_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t msg;
    string   fox;
    int      len;

    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    bus.s_last    = 1'b0;
    bus.hash_done = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_word_valid", 64'(bus.word_valid), 64'(0));
    check("rst_word", bus.word, 64'h0);
    check("rst_s_ready", 64'(bus.s_ready), 64'(0));
    check("rst_core_clr", 64'(bus.core_clr), 64'(0));
    tick();
    reset = 1'b0;
    tick();

    // Pangram, no back-pressure.
    fox = "The quick brown fox jumps over the lazy dog";
    msg = {};
    for (int i = 0; i < fox.len(); i++) msg.push_back(8'(fox[i]));
    push_model(msg);
    send_msg(msg, 0, 1'b1);
    finish_msg(1'b0);

    // Five bytes: one short last word.
    msg = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    expq.push_back(clr_ev());
    expq.push_back(word_ev(64'hA1A2A3A4A5000000, 1'b1, 3'd5));
    send_msg(msg, 1, 1'b1);
    finish_msg(1'b1);

    // Exactly eight bytes: full word then empty terminator.
    msg = {8'hc2, 8'h06, 8'h34, 8'hf3, 8'h57, 8'hf4, 8'h21, 8'hfb};
    expq.push_back(clr_ev());
    expq.push_back(word_ev(64'hc20634f357f421fb, 1'b0, 3'd0));
    expq.push_back(word_ev(64'h0, 1'b1, 3'd0));
    send_msg(msg, 0, 1'b1);
    finish_msg(1'b1);

    // Core holds buffer_full while the first word is pending.
    msg = {};
    for (int i = 0; i < 16; i++) msg.push_back(8'($urandom));
    push_model(msg);
    bf_mode = 2;
    fork
      send_msg(msg, 0, 1'b1);
      stall_probe();
    join
    finish_msg(1'b0);

    // Reset after 5 bytes of a 12-byte message: nothing may be emitted.
    msg = {};
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    expq.push_back(clr_ev());
    send_msg(msg, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_word", bus.word, 64'h0);
    check("mid_rst_word_valid", 64'(bus.word_valid), 64'(0));
    check("mid_rst_word_last", 64'(bus.word_last), 64'(0));
    check("mid_rst_word_bytes", 64'(bus.word_bytes), 64'(0));
    check("mid_rst_core_clr", 64'(bus.core_clr), 64'(0));
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'(0));
    check("mid_rst_pending", 64'(expq.size()), 64'(0));
    expq.delete();
    tick();
    reset = 1'b0;
    tick();
    msg = {};
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    push_model(msg);
    send_msg(msg, 0, 1'b1);
    finish_msg(1'b0);

    // Random messages under random back-pressure.
    bf_mode = 1;
    for (int m = 0; m < 12; m++) begin
      len = $urandom_range(1, 24);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      push_model(msg);
      send_msg(msg, 2, 1'b1);
      finish_msg(bit'($urandom_range(0, 1)));
    end
    bf_mode = 0;
    repeat (4) tick();

    check("final_pending", 64'(expq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
